chess_game_ctrl: RTL and testbench

Game sequencer for the chess clock. It turns the debounced front-panel buttons into the `enable`/`player`/`timeIn` controls that drive the two-counter countdown datapath. It watches the counters' min/sec outputs to detect flag fall and reports the winner and the number of completed moves. It sits between the button debouncers and the countdown block, in the same system clock domain.

---
 rtl/chess_game_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_chess_game_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/chess_game_ctrl.sv
// chess_game_ctrl
//   Game sequencer for the chess clock. Converts debounced front-panel button
//   levels into run/load commands for the two-counter countdown datapath,
//   detects flag fall from the counters' remaining time, and reports the
//   winner and the number of completed moves.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   btn_start         start / new game (level, rising edge is the event)
//   btn_pause         pause / resume   (level, rising edge is the event)
//   btn_p1, btn_p2    end-of-turn buttons (level, rising edge is the event)
//   time_sel[1:0]     game length: 00=1, 01=3, 10=5, 11=10 minutes
//   min1/sec1/min2/sec2[7:0]  remaining time from the countdown block
//   enable            run enable to the countdown block
//   player[1:0]       00=load both, 01=run counter 1, 10=run counter 2, 11=hold
//   timeIn[7:0]       minutes loaded into both counters
//   winner[1:0]       00=none, 01=player 1, 10=player 2
//   move_cnt[7:0]     completed moves, saturating at 255
//   state[2:0]        current FSM state code
//
// Handshake: there is no valid/ready pairing here; every button is a level
// and an event is a rising edge (high now, low at the previous clk edge).
// All outputs are registered and decoded from the next state, so they change
// on the same edge as the state register.
module chess_game_ctrl #(
    parameter int LOAD_CYCLES = 100_000_000,
    parameter int LOAD_W      = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_p1,
    input  logic       btn_p2,
    input  logic [1:0] time_sel,
    input  logic [7:0] min1,
    input  logic [7:0] sec1,
    input  logic [7:0] min2,
    input  logic [7:0] sec2,
    output logic       enable,
    output logic [1:0] player,
    output logic [7:0] timeIn,
    output logic [1:0] winner,
    output logic [7:0] move_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_READY  = 3'd2,
        S_RUN1   = 3'd3,
        S_RUN2   = 3'd4,
        S_PAUSE1 = 3'd5,
        S_PAUSE2 = 3'd6,
        S_OVER   = 3'd7
    } state_t;

    localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(LOAD_CYCLES - 1);

    state_t            cur_state;
    state_t            next_state;
    logic [LOAD_W-1:0] load_cnt;
    logic              prev_start, prev_pause, prev_p1, prev_p2;
    logic              ev_start, ev_pause, ev_p1, ev_p2;
    logic              flag1, flag2;

    logic              enable_d;
    logic [1:0]        player_d;
    logic [7:0]        timein_d;
    logic [1:0]        winner_d;
    logic [7:0]        move_d;

    assign ev_start = btn_start & ~prev_start;
    assign ev_pause = btn_pause & ~prev_pause;
    assign ev_p1    = btn_p1    & ~prev_p1;
    assign ev_p2    = btn_p2    & ~prev_p2;
    assign flag1    = (min1 == 8'd0) && (sec1 == 8'd0);
    assign flag2    = (min2 == 8'd0) && (sec2 == 8'd0);
    assign state    = cur_state;

    // State register, output registers, load counter and button history.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state  <= S_IDLE;
            load_cnt   <= '0;
            prev_start <= 1'b0;
            prev_pause <= 1'b0;
            prev_p1    <= 1'b0;
            prev_p2    <= 1'b0;
            enable     <= 1'b0;
            player     <= 2'b11;
            timeIn     <= 8'd1;
            winner     <= 2'b00;
            move_cnt   <= 8'd0;
        end else begin
            cur_state  <= next_state;
            prev_start <= btn_start;
            prev_pause <= btn_pause;
            prev_p1    <= btn_p1;
            prev_p2    <= btn_p2;
            if (cur_state == S_IDLE)
                load_cnt <= '0;
            else if (cur_state == S_LOAD)
                load_cnt <= load_cnt + LOAD_W'(1);
            enable     <= enable_d;
            player     <= player_d;
            timeIn     <= timein_d;
            winner     <= winner_d;
            move_cnt   <= move_d;
        end
    end

    // Next-state logic. In RUN states the flag outranks pause, which
    // outranks the turn button; in PAUSE states start outranks resume.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            S_IDLE:   if (ev_start) next_state = S_LOAD;
            S_LOAD:   if (load_cnt == LOAD_LAST) next_state = S_READY;
            S_READY:  if (ev_p2) next_state = S_RUN1;
            S_RUN1: begin
                if (flag1)         next_state = S_OVER;
                else if (ev_pause) next_state = S_PAUSE1;
                else if (ev_p1)    next_state = S_RUN2;
            end
            S_RUN2: begin
                if (flag2)         next_state = S_OVER;
                else if (ev_pause) next_state = S_PAUSE2;
                else if (ev_p2)    next_state = S_RUN1;
            end
            S_PAUSE1: begin
                if (ev_start)      next_state = S_IDLE;
                else if (ev_pause) next_state = S_RUN1;
            end
            S_PAUSE2: begin
                if (ev_start)      next_state = S_IDLE;
                else if (ev_pause) next_state = S_RUN2;
            end
            S_OVER:   if (ev_start) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Output decode from the next state and the transition being taken.
    always_comb begin
        enable_d = 1'b0;
        player_d = 2'b11;
        timein_d = timeIn;
        winner_d = winner;
        move_d   = move_cnt;

        case (next_state)
            S_LOAD: begin enable_d = 1'b1; player_d = 2'b00; end
            S_RUN1: begin enable_d = 1'b1; player_d = 2'b01; end
            S_RUN2: begin enable_d = 1'b1; player_d = 2'b10; end
            default: begin enable_d = 1'b0; player_d = 2'b11; end
        endcase

        // timeIn follows the selector only while idle; the value present at
        // the start event is the one frozen for the whole game.
        if (cur_state == S_IDLE) begin
            case (time_sel)
                2'b00:   timein_d = 8'd1;
                2'b01:   timein_d = 8'd3;
                2'b10:   timein_d = 8'd5;
                default: timein_d = 8'd10;
            endcase
        end

        // A completed turn is a RUN1<->RUN2 swap.
        if (((cur_state == S_RUN1) && (next_state == S_RUN2)) ||
            ((cur_state == S_RUN2) && (next_state == S_RUN1))) begin
            if (move_cnt != 8'hFF)
                move_d = move_cnt + 8'd1;
        end

        // Flag fall: the player whose clock ran out loses.
        if (next_state == S_OVER) begin
            if (cur_state == S_RUN1)      winner_d = 2'b10;
            else if (cur_state == S_RUN2) winner_d = 2'b01;
        end

        if (next_state == S_IDLE) begin
            winner_d = 2'b00;
            move_d   = 8'd0;
        end
    end

endmodule

// File: tb/tb_chess_game_ctrl.sv
module tb_chess_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start, btn_pause, btn_p1, btn_p2;
  logic [1:0] time_sel;
  logic [7:0] min1, sec1, min2, sec2;
  logic       enable;
  logic [1:0] player;
  logic [7:0] timeIn;
  logic [1:0] winner;
  logic [7:0] move_cnt;
  logic [2:0] state;

  int asserts = 0;
  int fails   = 0;

  chess_game_ctrl #(.LOAD_CYCLES(4), .LOAD_W(3)) dut (
    .clk(clk), .reset(reset),
    .btn_start(btn_start), .btn_pause(btn_pause),
    .btn_p1(btn_p1), .btn_p2(btn_p2),
    .time_sel(time_sel),
    .min1(min1), .sec1(sec1), .min2(min2), .sec2(sec2),
    .enable(enable), .player(player), .timeIn(timeIn),
    .winner(winner), .move_cnt(move_cnt), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks: inputs change on the falling edge, checks follow the next one
  task automatic pulse_start();
    @(negedge clk) btn_start = 1'b1;
    @(negedge clk) btn_start = 1'b0;
  endtask

  task automatic pulse_pause();
    @(negedge clk) btn_pause = 1'b1;
    @(negedge clk) btn_pause = 1'b0;
  endtask

  task automatic pulse_p1();
    @(negedge clk) btn_p1 = 1'b1;
    @(negedge clk) btn_p1 = 1'b0;
  endtask

  task automatic pulse_p2();
    @(negedge clk) btn_p2 = 1'b1;
    @(negedge clk) btn_p2 = 1'b0;
  endtask

  // start a game from IDLE and wait out the 4-cycle load
  task automatic start_game();
    pulse_start();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_start = 0; btn_pause = 0; btn_p1 = 0; btn_p2 = 0;
    time_sel = 2'b00;
    min1 = 8'd1; sec1 = 8'd30; min2 = 8'd1; sec2 = 8'd30;
    repeat (3) @(negedge clk);
    asserts++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
    asserts++; if (enable !== 1'b0) begin fails++; $display("FAIL reset_enable: got %0b expected 0", enable); end
    asserts++; if (player !== 2'b11) begin fails++; $display("FAIL reset_player: got %b expected 11", player); end
    asserts++; if (timeIn !== 8'd1) begin fails++; $display("FAIL reset_timein: got %0d expected 1", timeIn); end
    asserts++; if (winner !== 2'b00) begin fails++; $display("FAIL reset_winner: got %b expected 00", winner); end
    asserts++; if (move_cnt !== 8'd0) begin fails++; $display("FAIL reset_move: got %0d expected 0", move_cnt); end
    reset = 1'b0;
    time_sel = 2'b11;
    @(negedge clk);
    asserts++; if (timeIn !== 8'd10) begin fails++; $display("FAIL idle_track: got %0d expected 10", timeIn); end
  endtask

  task automatic test_load();
    int cnt;
    time_sel = 2'b10;
    @(negedge clk);
    pulse_start();
    asserts++; if (state !== 3'd1) begin fails++; $display("FAIL load_state: got %0d expected 1", state); end
    asserts++; if (timeIn !== 8'd5) begin fails++; $display("FAIL load_timein: got %0d expected 5", timeIn); end
    asserts++; if (enable !== 1'b1) begin fails++; $display("FAIL load_enable: got %0b expected 1", enable); end
    time_sel = 2'b00;  // must not disturb the latched length
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (player !== 2'b00) break;
      cnt++;
      @(negedge clk);
    end
    asserts++; if (cnt != 4) begin fails++; $display("FAIL load_len: got %0d expected 4", cnt); end
    asserts++; if (state !== 3'd2) begin fails++; $display("FAIL ready_state: got %0d expected 2", state); end
    asserts++; if (player !== 2'b11) begin fails++; $display("FAIL ready_player: got %b expected 11", player); end
    asserts++; if (enable !== 1'b0) begin fails++; $display("FAIL ready_enable: got %0b expected 0", enable); end
    asserts++; if (timeIn !== 8'd5) begin fails++; $display("FAIL load_hold: got %0d expected 5", timeIn); end
  endtask

  task automatic test_turns();
    pulse_p1();
    asserts++; if (state !== 3'd2) begin fails++; $display("FAIL ready_p1_ignored: got %0d expected 2", state); end
    pulse_p2();
    asserts++; if (state !== 3'd3 || player !== 2'b01) begin fails++; $display("FAIL turn1: got state %0d player %b expected 3 01", state, player); end
    asserts++; if (move_cnt !== 8'd0) begin fails++; $display("FAIL turn1_move: got %0d expected 0", move_cnt); end
    pulse_p1();
    asserts++; if (state !== 3'd4 || player !== 2'b10) begin fails++; $display("FAIL turn2: got state %0d player %b expected 4 10", state, player); end
    pulse_p2();
    asserts++; if (state !== 3'd3 || player !== 2'b01) begin fails++; $display("FAIL turn3: got state %0d player %b expected 3 01", state, player); end
    asserts++; if (move_cnt !== 8'd2) begin fails++; $display("FAIL turn_move: got %0d expected 2", move_cnt); end
  endtask

  task automatic test_held_button();
    @(negedge clk) btn_p1 = 1'b1;
    repeat (50) @(negedge clk);
    btn_p1 = 1'b0;
    asserts++; if (state !== 3'd4) begin fails++; $display("FAIL held_state: got %0d expected 4", state); end
    asserts++; if (move_cnt !== 8'd3) begin fails++; $display("FAIL held_move: got %0d expected 3", move_cnt); end
    pulse_p1();
    asserts++; if (state !== 3'd4 || move_cnt !== 8'd3) begin fails++; $display("FAIL run2_p1_ignored: got state %0d move %0d expected 4 3", state, move_cnt); end
    pulse_start();
    asserts++; if (state !== 3'd4) begin fails++; $display("FAIL run_start_ignored: got %0d expected 4", state); end
  endtask

  task automatic test_flag_priority();
    time_sel = 2'b11;
    @(negedge clk);
    min2 = 8'd0; sec2 = 8'd0; btn_p2 = 1'b1;
    @(negedge clk);
    btn_p2 = 1'b0; min2 = 8'd1; sec2 = 8'd30;
    asserts++; if (state !== 3'd7) begin fails++; $display("FAIL flag_state: got %0d expected 7", state); end
    asserts++; if (winner !== 2'b01) begin fails++; $display("FAIL flag_winner: got %b expected 01", winner); end
    asserts++; if (enable !== 1'b0 || player !== 2'b11) begin fails++; $display("FAIL flag_ctrl: got en %0b player %b expected 0 11", enable, player); end
    asserts++; if (move_cnt !== 8'd3) begin fails++; $display("FAIL flag_move: got %0d expected 3", move_cnt); end
    pulse_start();
    asserts++; if (state !== 3'd0 || winner !== 2'b00 || move_cnt !== 8'd0) begin fails++; $display("FAIL over_restart: got state %0d winner %b move %0d expected 0 00 0", state, winner, move_cnt); end
    asserts++; if (timeIn !== 8'd5) begin fails++; $display("FAIL restart_timein_hold: got %0d expected 5", timeIn); end
    @(negedge clk);
    asserts++; if (timeIn !== 8'd10) begin fails++; $display("FAIL restart_timein_track: got %0d expected 10", timeIn); end
  endtask

  task automatic test_pause_and_saturate();
    time_sel = 2'b00;
    start_game();
    asserts++; if (state !== 3'd2 || timeIn !== 8'd1) begin fails++; $display("FAIL game2_ready: got state %0d time %0d expected 2 1", state, timeIn); end
    pulse_p2();
    pulse_pause();
    asserts++; if (state !== 3'd5 || enable !== 1'b0 || player !== 2'b11) begin fails++; $display("FAIL pause1: got state %0d en %0b player %b expected 5 0 11", state, enable, player); end
    min1 = 8'd0; sec1 = 8'd0;
    repeat (3) @(negedge clk);
    asserts++; if (state !== 3'd5 || winner !== 2'b00) begin fails++; $display("FAIL pause_flag_ignored: got state %0d winner %b expected 5 00", state, winner); end
    min1 = 8'd1; sec1 = 8'd30;
    pulse_pause();
    asserts++; if (state !== 3'd3 || enable !== 1'b1) begin fails++; $display("FAIL resume1: got state %0d en %0b expected 3 1", state, enable); end
    for (int i = 0; i < 255; i++) begin
      if (i % 2 == 0) pulse_p1(); else pulse_p2();
    end
    asserts++; if (move_cnt !== 8'd255) begin fails++; $display("FAIL move_255: got %0d expected 255", move_cnt); end
    // 255 presses from RUN1 leave RUN2 active
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) pulse_p2(); else pulse_p1();
    end
    asserts++; if (move_cnt !== 8'd255) begin fails++; $display("FAIL move_sat: got %0d expected 255", move_cnt); end
    asserts++; if (state !== 3'd3) begin fails++; $display("FAIL sat_state: got %0d expected 3", state); end
    pulse_pause();
    @(negedge clk) begin btn_start = 1'b1; btn_pause = 1'b1; end
    @(negedge clk) begin btn_start = 1'b0; btn_pause = 1'b0; end
    asserts++; if (state !== 3'd0 || move_cnt !== 8'd0) begin fails++; $display("FAIL pause_start_wins: got state %0d move %0d expected 0 0", state, move_cnt); end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    @(negedge clk);
    asserts++; if (state !== 3'd1) begin fails++; $display("FAIL pre_reset_load: got %0d expected 1", state); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    asserts++; if (state !== 3'd0 || enable !== 1'b0 || player !== 2'b11 || winner !== 2'b00 || move_cnt !== 8'd0) begin fails++; $display("FAIL reset_in_load: got state %0d en %0b player %b winner %b move %0d", state, enable, player, winner, move_cnt); end
    start_game();
    pulse_p2();
    pulse_p1();
    asserts++; if (state !== 3'd4 || move_cnt !== 8'd1) begin fails++; $display("FAIL pre_reset_run2: got state %0d move %0d expected 4 1", state, move_cnt); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    asserts++; if (state !== 3'd0 || enable !== 1'b0 || player !== 2'b11 || winner !== 2'b00 || move_cnt !== 8'd0) begin fails++; $display("FAIL reset_in_run2: got state %0d en %0b player %b winner %b move %0d", state, enable, player, winner, move_cnt); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_turns();
    test_held_button();
    test_flag_priority();
    test_pause_and_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
